// File: rtl/mat_vec_dma.sv
// Strided vector mover between the matrix data memory and the matrix cache, one vector per clock.
// Optional transfer statistics (vec_count, stats_clear) are enabled with `define MAT_VEC_DMA_STATS_EN.

module mat_vec_dma_lane #(
    parameter int ELEM_BITS = 32
) (
    input  logic                 cache_wr_i,
    input  logic                 mem_wr_i,
    input  logic [ELEM_BITS-1:0] mem_rd_i,
    input  logic [ELEM_BITS-1:0] cache_rd_i,
    output logic [ELEM_BITS-1:0] cache_wr_o,
    output logic [ELEM_BITS-1:0] mem_wr_o
);
    // Write data is held at zero whenever its strobe is low so idle buses stay quiet.
    assign cache_wr_o = cache_wr_i ? mem_rd_i   : '0;
    assign mem_wr_o   = mem_wr_i   ? cache_rd_i : '0;
endmodule

module mat_vec_dma #(
    parameter int WIDTH              = 16,
    parameter int ELEM_BITS          = 32,
    parameter int CACHE_SIZE         = 8,
    parameter int CACHE_ADDR_SIZE    = $clog2(CACHE_SIZE),
    parameter int DATA_MEM_ADDR_SIZE = 32,
    parameter int COUNT_BITS         = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_dir,
    input  logic [DATA_MEM_ADDR_SIZE-1:0] cmd_mem_addr,
    input  logic [DATA_MEM_ADDR_SIZE-1:0] cmd_mem_stride,
    input  logic [CACHE_ADDR_SIZE-1:0]    cmd_cache_addr,
    input  logic [COUNT_BITS-1:0]         cmd_count,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          done_aborted,
    output logic [DATA_MEM_ADDR_SIZE-1:0] mem_read_addr,
    input  logic [WIDTH*ELEM_BITS-1:0]    mem_data_out,
    output logic                          mem_write_en,
    output logic [DATA_MEM_ADDR_SIZE-1:0] mem_write_addr,
    output logic [WIDTH*ELEM_BITS-1:0]    mem_data_in,
    output logic [CACHE_ADDR_SIZE-1:0]    cache_read_addr,
    input  logic [WIDTH*ELEM_BITS-1:0]    cache_data_out,
    output logic                          cache_write_en,
    output logic [CACHE_ADDR_SIZE-1:0]    cache_write_addr,
    output logic [WIDTH*ELEM_BITS-1:0]    cache_data_in
`ifdef MAT_VEC_DMA_STATS_EN
    ,
    input  logic                          stats_clear,
    output logic [31:0]                   vec_count
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CACHE_ADDR_SIZE-1:0] CACHE_LAST = CACHE_ADDR_SIZE'(CACHE_SIZE - 1);

    logic [1:0]                    state_q, state_d;
    logic                          dir_q, dir_d;
    logic                          aborted_q, aborted_d;
    logic [DATA_MEM_ADDR_SIZE-1:0] stride_q, stride_d;
    logic [DATA_MEM_ADDR_SIZE-1:0] cur_mem_q, cur_mem_d;
    logic [CACHE_ADDR_SIZE-1:0]    cur_cache_q, cur_cache_d;
    logic [COUNT_BITS-1:0]         remaining_q, remaining_d;

    logic xfer;
    logic move;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        aborted_d   = aborted_q;
        stride_d    = stride_q;
        cur_mem_d   = cur_mem_q;
        cur_cache_d = cur_cache_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    stride_d    = cmd_mem_stride;
                    cur_mem_d   = cmd_mem_addr;
                    cur_cache_d = cmd_cache_addr;
                    remaining_d = cmd_count;
                    aborted_d   = 1'b0;
                    state_d     = (cmd_count != '0) ? S_XFER : S_DONE;
                end
            end
            S_XFER: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cur_mem_d   = cur_mem_q + stride_q;
                    // Explicit wrap so non power-of-two cache depths stay in range.
                    cur_cache_d = (cur_cache_q == CACHE_LAST) ? '0
                                                              : cur_cache_q + CACHE_ADDR_SIZE'(1);
                    remaining_d = remaining_q - COUNT_BITS'(1);
                    if (remaining_q == COUNT_BITS'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            dir_q       <= 1'b0;
            aborted_q   <= 1'b0;
            stride_q    <= '0;
            cur_mem_q   <= '0;
            cur_cache_q <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            aborted_q   <= aborted_d;
            stride_q    <= stride_d;
            cur_mem_q   <= cur_mem_d;
            cur_cache_q <= cur_cache_d;
            remaining_q <= remaining_d;
        end
    end

    // Strobes come straight from state so an async reset drops them at once.
    assign xfer = (state_q == S_XFER);
    assign move = xfer && !abort;

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = xfer;
    assign done         = (state_q == S_DONE);
    assign done_aborted = done && aborted_q;

    assign mem_read_addr    = (xfer && !dir_q) ? cur_mem_q   : '0;
    assign cache_write_addr = (xfer && !dir_q) ? cur_cache_q : '0;
    assign cache_read_addr  = (xfer &&  dir_q) ? cur_cache_q : '0;
    assign mem_write_addr   = (xfer &&  dir_q) ? cur_mem_q   : '0;
    assign cache_write_en   = move && !dir_q;
    assign mem_write_en     = move &&  dir_q;

    for (genvar l = 0; l < WIDTH; l++) begin : g_lane
        mat_vec_dma_lane #(.ELEM_BITS(ELEM_BITS)) u_lane (
            .cache_wr_i (cache_write_en),
            .mem_wr_i   (mem_write_en),
            .mem_rd_i   (mem_data_out[l*ELEM_BITS +: ELEM_BITS]),
            .cache_rd_i (cache_data_out[l*ELEM_BITS +: ELEM_BITS]),
            .cache_wr_o (cache_data_in[l*ELEM_BITS +: ELEM_BITS]),
            .mem_wr_o   (mem_data_in[l*ELEM_BITS +: ELEM_BITS])
        );
    end

`ifdef MAT_VEC_DMA_STATS_EN
    logic [31:0] vec_count_q, vec_count_d;

    always_comb begin
        vec_count_d = vec_count_q;
        if (stats_clear)
            vec_count_d = {31'd0, move};
        else if (move)
            vec_count_d = vec_count_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) vec_count_q <= '0;
        else        vec_count_q <= vec_count_d;
    end

    assign vec_count = vec_count_q;
`endif
endmodule
